button_conditioner: RTL and testbench

// Raw push-button front end that produces the clean single-cycle press strobe the piece counter consumes on button_i.

---
 rtl/button_conditioner.sv | 172 +++++++++++++++++
 tb/tb_button_conditioner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: 2-FF synchroniser, 4-state debounce FSM, press/release strobes.
// Optional auto-repeat of the press strobe while held, enabled by defining BUTTON_AUTOREPEAT_EN.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_RATE     = 16
) (
  input  logic       clk,
  input  logic       nRst_i,
  input  logic       button_i,
  output logic       pulse_o,
  output logic       release_o,
  output logic       level_o,
  output logic [1:0] state_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Reject parameter values the counters cannot represent
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_repeat
    $error("REPEAT_RATE must be in 1..REPEAT_DELAY");
  end

  logic           s1;
  logic           s2;
  state_t         state_q;
  state_t         state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic           pulse_q;
  logic           pulse_d;
  logic           release_q;
  logic           release_d;
  logic           level_q;
  logic           level_d;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

  logic [RPT_W-1:0] rpt_q;
  logic [RPT_W-1:0] rpt_d;
`endif

  // Two-stage synchroniser for the asynchronous pad level
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button_i;
      s2 <= s1;
    end
  end

  // Debounce FSM next-state, counter and strobe decisions
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    release_d = 1'b0;
    level_d   = level_q;
`ifdef BUTTON_AUTOREPEAT_EN
    rpt_d     = rpt_q;
`endif
    case (state_q)
      IDLE: begin
        if (s2) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
          level_d = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
`ifdef BUTTON_AUTOREPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
`ifdef BUTTON_AUTOREPEAT_EN
          // First strobe after the full delay, then reload so later ones come every REPEAT_RATE
          if (rpt_q == RPT_LAST) begin
            pulse_d = 1'b1;
            rpt_d   = RPT_RELOAD;
          end else begin
            rpt_d = rpt_q + RPT_W'(1);
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          // Bounce during release: back to held, no new press strobe
          state_d = PRESSED;
          cnt_d   = '0;
`ifdef BUTTON_AUTOREPEAT_EN
          rpt_d   = '0;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
      level_q   <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      release_q <= release_d;
      level_q   <= level_d;
`ifdef BUTTON_AUTOREPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign pulse_o   = pulse_q;
  assign release_o = release_q;
  assign level_o   = level_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: directed scenarios plus random press/release bursts.
module tb_button_conditioner;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned RR = 4;

  logic       clk = 1'b0;
  logic       nRst_i;
  logic       button_i;
  logic       pulse_o;
  logic       release_o;
  logic       level_o;
  logic [1:0] state_o;

  typedef struct packed {
    logic       pulse;
    logic       rel;
    logic       level;
    logic [1:0] state;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e;
  obs_t mon_a;
  int   errors = 0;
  int   checks = 0;

  // Reference model: input seen by the debouncer two edges late; level flips after D
  // consecutive samples that disagree with it; any agreeing sample restarts the count.
  bit m_d1;
  bit m_d2;
  bit m_level;
  int m_run;
  int m_since;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk      (clk),
    .nRst_i   (nRst_i),
    .button_i (button_i),
    .pulse_o  (pulse_o),
    .release_o(release_o),
    .level_o  (level_o),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_d1    = 1'b0;
    m_d2    = 1'b0;
    m_level = 1'b0;
    m_run   = 0;
    m_since = 0;
  endtask

  task automatic model_edge(input bit b);
    bit   samp;
    bit   p;
    bit   r;
    obs_t e;
    samp = m_d2;
    m_d2 = m_d1;
    m_d1 = b;
    p = 1'b0;
    r = 1'b0;
    if (samp != m_level) begin
      m_run++;
      if (m_run == int'(D)) begin
        m_level = samp;
        m_run   = 0;
        m_since = 0;
        if (samp) p = 1'b1;
        else      r = 1'b1;
      end
    end else if (m_run != 0) begin
      m_run   = 0;
      m_since = 0;
    end else if (m_level) begin
`ifdef BUTTON_AUTOREPEAT_EN
      m_since++;
      if (m_since >= int'(RD) && ((m_since - int'(RD)) % int'(RR)) == 0) p = 1'b1;
`endif
    end
    e.pulse = p;
    e.rel   = r;
    e.level = m_level;
    e.state = {m_level, (m_run != 0)};
    exp_q.push_back(e);
  endtask

  task automatic step(input bit b);
    #1 button_i = b;
    @(posedge clk);
    model_edge(b);
  endtask

  task automatic hold(input bit b, input int n);
    for (int k = 0; k < n; k++) step(b);
  endtask

  task automatic apply_reset(input int n);
    obs_t z;
    z = '0;
    @(negedge clk);
    #1 nRst_i = 1'b0;
    #1;
    checks++;
    if ({pulse_o, release_o, level_o, state_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_immediate t=%0t got pulse/rel/level/state=%b/%b/%b/%0d want 0/0/0/0",
               $time, pulse_o, release_o, level_o, state_o);
    end
    model_reset();
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      exp_q.push_back(z);
    end
    @(negedge clk);
    #1 nRst_i = 1'b1;
  endtask

  // Monitor: compare every presented output cycle against the next scoreboard entry
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {pulse_o, release_o, level_o, state_o};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t pulse/rel/level/state got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 $time, mon_a.pulse, mon_a.rel, mon_a.level, mon_a.state,
                 mon_e.pulse, mon_e.rel, mon_e.level, mon_e.state);
      end
    end
  end

  // Stimulus: directed scenarios, then random bursts with occasional resets
  initial begin
    int lv;
    int n;
    nRst_i   = 1'b1;
    button_i = 1'b0;
    model_reset();
    apply_reset(2);

    // clean press and release
    hold(1'b1, 30);
    hold(1'b0, 30);
    // short glitch
    hold(1'b1, 3);
    hold(1'b0, 10);
    // bouncy press then bouncy release
    step(1'b1); step(1'b0); step(1'b1); step(1'b1); step(1'b0); step(1'b1);
    hold(1'b1, 15);
    step(1'b0); step(1'b1); step(1'b0);
    hold(1'b0, 15);
    // reset while in PRESS_WAIT with button held
    hold(1'b1, 4);
    apply_reset(2);
    hold(1'b1, 20);
    hold(1'b0, 12);
    // reset while PRESSED
    hold(1'b1, 10);
    apply_reset(1);
    hold(1'b0, 10);
    // long hold
    hold(1'b1, 60);
    hold(1'b0, 12);

    for (int i = 0; i < 400; i++) begin
      lv = int'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 6) n = int'($urandom_range(1, D + 1));
      else                          n = int'($urandom_range(D + 2, 3 * RD));
      hold(lv[0], n);
      if ($urandom_range(0, 49) == 0) apply_reset(int'($urandom_range(1, 3)));
    end
    hold(1'b0, 20);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
